// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: walks enabled channels in ascending order, holding each for dwell+1 cycles, to drive a 3-to-8 decoder
// Ports: clk, rst_n (async active-low); start/stop (single-cycle controls); mode (0 continuous, 1 single pass);
//        dwell (hold count); ch_mask (channel enables); sel/sel_vld (decoder select and enable);
//        busy (scan in progress); pass_done (end-of-pass pulse); err (no enabled channel pulse).
module decoder_scan_sequencer #(
  parameter int DWELL_W = 8,
  parameter int NUM_CH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         mode,
  input  logic [DWELL_W-1:0]           dwell,
  input  logic [NUM_CH-1:0]            ch_mask,
  output logic [$clog2(NUM_CH)-1:0]    sel,
  output logic                         sel_vld,
  output logic                         busy,
  output logic                         pass_done,
  output logic                         err
);
  localparam int SW = $clog2(NUM_CH);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_d;
  logic [SW-1:0] sel_d;
  logic [DWELL_W-1:0] cnt, cnt_d, dwell_q, dwell_d;
  logic [NUM_CH-1:0] mask_q, mask_d, nxt;
  logic mode_q, mode_d, pd_d, err_d;
  function automatic logic [SW-1:0] low_bit(input logic [NUM_CH-1:0] m);
    low_bit = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) low_bit = SW'(i);
  endfunction
  // enabled channels strictly above the current one
  function automatic logic [NUM_CH-1:0] above(input logic [NUM_CH-1:0] m, input logic [SW-1:0] s);
    for (int i = 0; i < NUM_CH; i++) above[i] = m[i] && (i > int'(s));
  endfunction
  assign nxt = above(mask_q, sel);
  always_comb begin
    state_d = state;
    sel_d = sel;
    cnt_d = cnt;
    mask_d = mask_q;
    dwell_d = dwell_q;
    mode_d = mode_q;
    pd_d = 1'b0;
    err_d = 1'b0;
    if (state == IDLE) begin
      if (start && !stop) begin
        mask_d = ch_mask;
        dwell_d = dwell;
        mode_d = mode;
        if (|ch_mask) begin
          sel_d = low_bit(ch_mask);
          cnt_d = '0;
          state_d = SCAN;
        end else err_d = 1'b1;
      end
    end else if (stop) state_d = IDLE;
    else if (cnt != dwell_q) cnt_d = cnt + 1'b1;
    else if (|nxt) begin
      sel_d = low_bit(nxt);
      cnt_d = '0;
    end else begin
      pd_d = 1'b1;
      if (mode_q) state_d = IDLE;
      else begin
        // continuous wrap picks up the live mask; an empty one ends the scan
        mask_d = ch_mask;
        if (|ch_mask) begin
          sel_d = low_bit(ch_mask);
          cnt_d = '0;
        end else begin
          state_d = IDLE;
          err_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      sel_vld <= 1'b0;
      busy <= 1'b0;
      pass_done <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
      mask_q <= '0;
      dwell_q <= '0;
      mode_q <= 1'b0;
    end else begin
      state <= state_d;
      sel <= sel_d;
      sel_vld <= state_d == SCAN;
      busy <= state_d == SCAN;
      pass_done <= pd_d;
      err <= err_d;
      cnt <= cnt_d;
      mask_q <= mask_d;
      dwell_q <= dwell_d;
      mode_q <= mode_d;
    end
  end
endmodule
